au_unit: RTL and testbench

Registered N-bit arithmetic unit for the MIPS execute stage. It adds or subtracts two operands in signed or unsigned mode and returns the wrapped sum. It also returns an overflow flag and a "true-sign" negative flag, used for add/addu/sub/subu and for set-less-than style comparisons. Operands are captured on a valid strobe, and results with their flags are registered with one-cycle latency.

---
 rtl/au_unit.sv | 63 ++++++
 tb/tb_au_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/au_unit.sv
// Registered add/subtract unit for the MIPS execute stage: wrapped sum plus overflow and true-sign flags.
// Optional macro AU_ZERO_FLAG_EN registers a result-is-zero flag; otherwise zero is tied low.
module au_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         u,
  input  logic         sub,
  output logic         out_valid,
  output logic [N-1:0] s,
  output logic         ovf,
  output logic         neg,
  output logic         zero
);

  logic [N-1:0] bb;
  logic [N-1:0] s_next;
  logic         cout;
  logic         ovf_signed;
  logic         ovf_next;
  logic         neg_next;

  // Subtraction is a + ~b + 1, so one adder serves both operations.
  always_comb begin
    bb            = sub ? ~b : b;
    {cout, s_next} = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    ovf_signed    = (a[N-1] == bb[N-1]) && (s_next[N-1] != a[N-1]);
    ovf_next      = ~u & ovf_signed;
    // neg is the sign of the exact result: a borrow for unsigned sub, sign corrected by overflow for signed.
    if (u) neg_next = sub & ~cout;
    else   neg_next = s_next[N-1] ^ ovf_signed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s   <= s_next;
        ovf <= ovf_next;
        neg <= neg_next;
      end
    end
  end

`ifdef AU_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         zero <= 1'b0;
    else if (in_valid) zero <= (s_next == '0);
  end
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_au_unit.sv
// Directed and short random checks of au_unit (N=32), with immediate assertions at every comparison.
module tb_au_unit;

`ifdef AU_ZERO_FLAG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] a, b;
  logic        u, sub;
  logic        out_valid;
  logic [31:0] s;
  logic        ovf, neg, zero;

  int total = 0;
  int bad   = 0;

  au_unit #(.N(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .u(u), .sub(sub),
    .out_valid(out_valid), .s(s), .ovf(ovf), .neg(neg), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] es,
                           input logic eovf, input logic eneg, input logic ez);
    check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ev});
    check({tag, ".s"},         s,                  es);
    check({tag, ".ovf"},       {31'b0, ovf},       {31'b0, eovf});
    check({tag, ".neg"},       {31'b0, neg},       {31'b0, eneg});
    check({tag, ".zero"},      {31'b0, zero},      {31'b0, ez});
  endtask

  // Exact 34-bit arithmetic reference: overflow means the result does not fit in 32 signed bits.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mu, input logic msub,
                       output logic [31:0] ms, output logic movf, output logic mneg);
    logic [33:0] xa, xb, ex;
    xa = mu ? {2'b00, ma} : {{2{ma[31]}}, ma};
    xb = mu ? {2'b00, mb} : {{2{mb[31]}}, mb};
    ex = msub ? xa - xb : xa + xb;
    ms   = ex[31:0];
    movf = !mu && (ex[32] != ex[31]);
    mneg = ex[33];
  endtask

  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic tu, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; u = tu; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] es, input logic eovf, input logic eneg);
    check_all(tag, 1'b1, es, eovf, eneg, ZERO_EN && (es == 32'h0));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hs;
    logic        hovf, hneg, hz;
    logic [31:0] ra, rb;
    logic        ru, rsub;
    logic [31:0] ms;
    logic        movf, mneg;

    reset = 1'b1; in_valid = 1'b1;
    a = 32'h1234_5678; b = 32'h0000_0001; u = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("after_release", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    applyStimulus(32'h1111_1111, 32'hEEEE_EEEE, 1'b1, 1'b0);
    checkOutput("addu", 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle_cycle();
    check("addu_pulse_once", {31'b0, out_valid}, 32'h0);
    applyStimulus(32'h1111_1111, 32'hEEEE_EEEE, 1'b0, 1'b0);
    checkOutput("add", 32'hFFFF_FFFF, 1'b0, 1'b1);
    applyStimulus(32'h1111_1111, 32'hEEEE_EEEE, 1'b0, 1'b1);
    checkOutput("sub", 32'h2222_2223, 1'b0, 1'b0);
    applyStimulus(32'h1111_1111, 32'hEEEE_EEEE, 1'b1, 1'b1);
    checkOutput("subu", 32'h2222_2223, 1'b0, 1'b1);

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("add_ovf", 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    checkOutput("addu_noovf", 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    checkOutput("subu_noovf", 32'h7FFF_FFFF, 1'b0, 1'b0);
    applyStimulus(32'h5A5A_A5A5, 32'h5A5A_A5A5, 1'b1, 1'b1);
    checkOutput("subu_self", 32'h0000_0000, 1'b0, 1'b0);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    checkOutput("addu_wrap", 32'h0000_0000, 1'b0, 1'b0);
    hs = 32'h0; hovf = 1'b0; hneg = 1'b0; hz = ZERO_EN;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 32'h0F0F_0000 + i; b = 32'h1234_0000 - i; u = 1'b0; sub = ~sub;
      @(posedge clk);
      #1;
      check_all($sformatf("hold%0d", i), 1'b0, hs, hovf, hneg, hz);
    end

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; ru = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      if (i == 0) rb = ra;
      if (i == 1) begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
      applyStimulus(ra, rb, ru, rsub);
      model(ra, rb, ru, rsub, ms, movf, mneg);
      checkOutput($sformatf("rand%0d", i), ms, movf, mneg);
    end
    idle_cycle();
    check("rand_end_valid", {31'b0, out_valid}, 32'h0);

    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    checkOutput("pre_reset", 32'hFFFF_FFFE, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_all("async_reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
